// File: rtl/seq_check_1101_pkg.sv
// Shared types for the 1101 serial pattern detector: state encoding and the
// reference pattern used by bench models.
package seq_check_1101_pkg;

  typedef enum logic [1:0] {
    S0   = 2'b00,
    S1   = 2'b01,
    S11  = 2'b10,
    S110 = 2'b11
  } state_e;

  localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/seq_check_1101.sv
// Serial 1101 detector: one bit per clock, registered one-cycle match flag
// and a saturating match counter.
module seq_check_1101
  import seq_check_1101_pkg::*;
#(
  parameter bit OVERLAP = 1'b1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  output logic             flag_out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e state, state_nxt;
  logic   match;

  // State tracks the longest prefix of 1101 that ends the stream so far.
  always_comb begin
    state_nxt = S0;
    match     = 1'b0;
    case (state)
      S0:   state_nxt = data_in ? S1 : S0;
      S1:   state_nxt = data_in ? S11 : S0;
      S11:  state_nxt = data_in ? S11 : S110;
      S110: begin
        if (data_in) begin
          match     = 1'b1;
          // The closing '1' doubles as the first bit of the next pattern.
          state_nxt = OVERLAP ? S1 : S0;
        end else begin
          state_nxt = S0;
        end
      end
      default: begin
        state_nxt = S0;
        match     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S0;
      flag_out  <= 1'b0;
      match_cnt <= '0;
    end else begin
      state    <= state_nxt;
      flag_out <= match;
      if (match && (match_cnt != CNT_MAX))
        match_cnt <= match_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_seq_check_1101.sv
// Randomised and directed bench for seq_check_1101 against a sliding-window
// reference model; covers overlap, non-overlap and a 2-bit saturating counter.
module tb_seq_check_1101;
  import seq_check_1101_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_in = 1'b0;
  logic       flag_ov, flag_no, flag_sat;
  logic [7:0] cnt_ov, cnt_no;
  logic [1:0] cnt_sat;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_check_1101 #(.OVERLAP(1'b1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .flag_out(flag_ov), .match_cnt(cnt_ov));

  seq_check_1101 #(.OVERLAP(1'b0), .CNT_W(8)) dut_no (
    .clk(clk), .rst(rst), .data_in(data_in), .flag_out(flag_no), .match_cnt(cnt_no));

  seq_check_1101 #(.OVERLAP(1'b1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .data_in(data_in), .flag_out(flag_sat), .match_cnt(cnt_sat));

  // Model: last four bits seen since the window was (re)opened.
  logic [3:0] h_ov = '0, h_no = '0;
  int  n_ov = 0, n_no = 0, c_ov = 0, c_no = 0;
  bit  f_ov = 0, f_no = 0;
  bit  e_f_ov = 0, e_f_no = 0;
  int  e_c_ov = 0, e_c_no = 0, e_c_sat = 0;
  bit  cmp_en = 0;
  bit  prev_flag = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit d, input bit r);
    data_in = d;
    rst     = r;
    if (r) begin
      n_ov = 0; n_no = 0; c_ov = 0; c_no = 0; f_ov = 0; f_no = 0;
    end else begin
      h_ov = {h_ov[2:0], d};
      if (n_ov < 4) n_ov++;
      f_ov = (n_ov == 4) && (h_ov == PATTERN);
      if (f_ov) c_ov++;
      h_no = {h_no[2:0], d};
      if (n_no < 4) n_no++;
      f_no = (n_no == 4) && (h_no == PATTERN);
      if (f_no) begin
        c_no++;
        n_no = 0;
      end
    end
    @(posedge clk);
    #1;
    e_f_ov  = f_ov;
    e_f_no  = f_no;
    e_c_ov  = (c_ov > 255) ? 255 : c_ov;
    e_c_no  = (c_no > 255) ? 255 : c_no;
    e_c_sat = (c_ov > 3) ? 3 : c_ov;
    cmp_en  = 1;
  endtask

  task automatic drive_bits(input logic [15:0] bits, input int len);
    for (int i = len - 1; i >= 0; i--) step(bits[i], 1'b0);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("flag_ov", int'(flag_ov), int'(e_f_ov));
      chk("flag_no", int'(flag_no), int'(e_f_no));
      chk("flag_sat", int'(flag_sat), int'(e_f_ov));
      chk("cnt_ov", int'(cnt_ov), e_c_ov);
      chk("cnt_no", int'(cnt_no), e_c_no);
      chk("cnt_sat", int'(cnt_sat), e_c_sat);
      chk("flag_not_twice", int'(prev_flag && flag_ov), 0);
      prev_flag = flag_ov;
    end
  end

  initial begin
    // Reset with idle zeros, then idle after release.
    repeat (100) step(1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0);
    @(negedge clk); #1;
    chk("idle_cnt", int'(cnt_ov), 0);
    chk("idle_flag", int'(flag_ov), 0);

    // Single match: flag in the cycle after the final bit, gone the next.
    drive_bits(16'b1101, 4);
    @(negedge clk); #1;
    chk("single_flag", int'(flag_ov), 1);
    chk("single_cnt", int'(cnt_ov), 1);
    step(1'b0, 1'b0);
    @(negedge clk); #1;
    chk("single_flag_clr", int'(flag_ov), 0);

    // Overlapping stream.
    step(1'b0, 1'b1);
    drive_bits(16'b1101101, 7);
    @(negedge clk); #1;
    chk("ovl_cnt", int'(cnt_ov), 2);
    chk("novl_cnt", int'(cnt_no), 1);
    chk("ovl_flag_last", int'(flag_ov), 1);
    chk("novl_flag_last", int'(flag_no), 0);

    // Prefix robustness.
    step(1'b0, 1'b1);
    drive_bits(16'b111101, 6);
    @(negedge clk); #1;
    chk("run_ones_cnt", int'(cnt_ov), 1);
    step(1'b0, 1'b1);
    drive_bits(16'b11001101, 8);
    @(negedge clk); #1;
    chk("double_zero_cnt", int'(cnt_ov), 1);
    chk("double_zero_flag", int'(flag_ov), 1);

    // Mid-pattern reset discards progress.
    step(1'b0, 1'b1);
    drive_bits(16'b110, 3);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    @(negedge clk); #1;
    chk("midrst_flag", int'(flag_ov), 0);
    chk("midrst_cnt", int'(cnt_ov), 0);
    drive_bits(16'b1101, 4);
    @(negedge clk); #1;
    chk("midrst_fresh_cnt", int'(cnt_ov), 1);

    // Random soak with occasional resets.
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, ($urandom_range(0, 99) == 0));

    // Force saturation of the 2-bit counter.
    step(1'b0, 1'b1);
    repeat (5) drive_bits(16'b1101, 4);
    @(negedge clk); #1;
    chk("sat_cnt", int'(cnt_sat), 3);
    chk("nosat_cnt", int'(cnt_ov), 5);
    step(1'b0, 1'b0);

    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
